// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite slave bus bundle for the register bank.
// Signal names follow the AXI port naming used by the interconnect.
interface axi_lite_reg_bank_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// Parametrised AXI4-Lite register bank with byte strobes,
// read-only fabric-fed registers and per-register write pulses.
module axi_lite_reg_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic ACLK,
  input  logic ARESET,
  axi_lite_reg_bank_if.slave s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam int ADDR_LSB = (DW == 64) ? 3 : 2;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA, W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [DW-1:0] regs_q [NUM_REGS];

  logic          awready_c, wready_c;
  logic          aw_hs, w_hs, commit;
  logic [AW-1:0] awaddr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic [31:0]   wr_idx;
  logic [NUM_REGS-1:0] wr_sel, wr_hit;
  logic          wr_ok;
  logic [1:0]    bresp_q;
  logic [NUM_REGS-1:0] pulse_q;

  logic          arready_c, ar_hs;
  logic [31:0]   rd_idx;
  logic [DW-1:0] rd_val, rdata_q;
  logic [1:0]    rd_resp, rresp_q;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] data,
    input logic [SW-1:0] strb
  );
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  // Write FSM: ready levels, handshakes and next state.
  // Readies are forced low while reset is held.
  always_comb begin
    wstate_d  = wstate_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    commit    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_c = !ARESET;
        wready_c  = !ARESET;
      end
      W_ADDR: wready_c = !ARESET;
      W_DATA: awready_c = !ARESET;
      default: ;
    endcase
    aw_hs = s_axi.S_AXI_AWVALID && awready_c;
    w_hs  = s_axi.S_AXI_WVALID && wready_c;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_ADDR;
        end else if (w_hs) begin
          wstate_d = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_DATA: begin
        if (aw_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Pick held or live address/data and decode the target.
  always_comb begin
    wr_addr = (wstate_q == W_ADDR) ?
              awaddr_q : s_axi.S_AXI_AWADDR;
    wr_data = (wstate_q == W_DATA) ?
              wdata_q : s_axi.S_AXI_WDATA;
    wr_strb = (wstate_q == W_DATA) ?
              wstrb_q : s_axi.S_AXI_WSTRB;
    wr_idx  = 32'(wr_addr[AW-1:ADDR_LSB]);
    wr_sel  = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = (wr_idx == i);
    wr_ok  = (wr_idx < NUM_REGS) &&
             !(|(wr_sel & RO_MASK));
    wr_hit = (commit && wr_ok) ? wr_sel : '0;
  end

  // Write state, held channel contents, response and pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
      pulse_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      pulse_q  <= wr_hit;
      if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
    end
  end

  // Register storage; read-only slots keep their reset value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_hit[i])
          regs_q[i] <= merge(regs_q[i], wr_data, wr_strb);
    end
  end

  // Read FSM: accept one address, hold data until taken.
  always_comb begin
    rstate_d  = rstate_q;
    arready_c = 1'b0;
    ar_hs     = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_c = !ARESET;
        ar_hs = s_axi.S_AXI_ARVALID && arready_c;
        if (ar_hs) rstate_d = R_DATA;
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read source select: fabric input or internal register.
  always_comb begin
    rd_idx  = 32'(s_axi.S_AXI_ARADDR[AW-1:ADDR_LSB]);
    rd_val  = '0;
    rd_resp = (rd_idx < NUM_REGS) ? OKAY : SLVERR;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == i)
        rd_val = RO_MASK[i] ? reg_in[i*DW +: DW]
                            : regs_q[i];
  end

  // Read state and registered response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_resp;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs_q[g];
  end

  assign s_axi.S_AXI_AWREADY = awready_c;
  assign s_axi.S_AXI_WREADY  = wready_c;
  assign s_axi.S_AXI_BVALID  = (wstate_q == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_c;
  assign s_axi.S_AXI_RVALID  = (rstate_q == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign wr_pulse            = pulse_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT,
                       s_axi.S_AXI_ARPROT,
                       wr_addr[ADDR_LSB-1:0],
                       s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};
endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
Parametrised AXI4-Lite slave register bank, the next generation of the Controller's fixed four-register slave. It adds configurable register count and data width, byte-strobe writes, and per-register read-only mapping fed from fabric logic. It also adds SLVERR decoding and independent AW/W channel acceptance. The bank sits between the AXI interconnect and Game-of-Life control/status logic, exposing every register as a flat vector with per-register write pulses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; 32 or 64 only.
C_S_AXI_ADDR_WIDTH, 6, byte address width.
NUM_REGS, 8, number of registers; 1..2^(C_S_AXI_ADDR_WIDTH-ADDR_LSB).
RO_MASK, 0, NUM_REGS bits; bit i set means register i is read-only and reads reg_in slice i.
RESET_VALUE, 0, reset value applied to every writable register.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
reg_out  out  NUM_REGS*C_S_AXI_DATA_WIDTH  flat register contents; register i at slice i.
reg_in  in  NUM_REGS*C_S_AXI_DATA_WIDTH  read-only register sources.
wr_pulse  out  NUM_REGS  one-cycle strobe when register i is updated.

Behaviour:
- Reset values: all READY/VALID low while ARESET is high; BRESP, RRESP, RDATA and wr_pulse are 0; writable registers load RESET_VALUE; both FSMs return to idle. Any in-flight transaction is dropped with no response.
- Address decode: ADDR_LSB = log2(C_S_AXI_DATA_WIDTH/8). Index = addr >> ADDR_LSB. Address bits below ADDR_LSB are ignored.
  - Index >= NUM_REGS gives DECERR-free SLVERR (2'b10).
  - Write to a RO_MASK register gives SLVERR and leaves the register unchanged.
- Write FSM states and ready levels:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_ADDR (address held, awaiting data): AWREADY=0, WREADY=1.
  - W_DATA (data held, awaiting address): AWREADY=1, WREADY=0.
  - W_RESP: both readies 0.
- Write transitions:
  - AW-only handshake: W_IDLE -> W_ADDR. W-only handshake: W_IDLE -> W_DATA.
  - Both handshakes in the same cycle, or completing the missing one, -> W_RESP.
  - On entry to W_RESP (same edge): the register commits, BVALID rises and BRESP is set.
- Write timing:
  - Latency is 1 cycle from the later handshake to BVALID.
  - Only bytes with WSTRB set update. WSTRB=0 to a valid writable register returns OKAY, leaves data unchanged and still pulses wr_pulse.
  - wr_pulse[i] is high exactly in the first cycle BVALID is high, for OKAY writes only.
- Write response: BVALID holds with a stable BRESP until BREADY. Handshake -> W_IDLE; a new AW/W is accepted from the next cycle.
- Read FSM states: R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
  - On AR handshake, RDATA and RRESP are registered; RVALID rises the next cycle (latency 1).
  - Read source: reg_in slice for RO registers, the internal register otherwise. Out-of-range reads return RDATA=0, RRESP=SLVERR.
  - RDATA/RRESP hold stable until RREADY; handshake -> R_IDLE.
- Read and write channels are fully independent.
  - A read of register i on the same edge that register i commits returns the pre-write value.
- reg_out reflects internal registers continuously. RO slices of reg_out carry the RESET_VALUE register, which is never written.
- Reset asserted mid-transaction forces idle asynchronously. After release, the master must reissue.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to addresses 0x0, 0x4, 0x8, 0xC, each read back -> BRESP=RRESP=0, RDATA matches, wr_pulse[0..3] each high exactly 1 cycle.
- Register 1 holds 0xabcd0001; write 0x11223344 with WSTRB=4'b0101 -> read 0xab220044.
- Write to 0x20 with NUM_REGS=8 -> BRESP=2'b10, no wr_pulse. Read 0x3C -> RDATA=0, RRESP=2'b10.
- RO_MASK=8'h04, reg_in slice 2=0xCAFEF00D: read 0x8 -> 0xCAFEF00D, OKAY. Write 0x8 -> SLVERR; the reg_out slice stays RESET_VALUE.
- AWVALID 3 cycles before WVALID, and the reverse order, with BREADY low 5 cycles -> BVALID one cycle after the second handshake, held 5 cycles, no further AW/W accepted meanwhile.
- Assert ARESET while in W_ADDR and R_DATA -> all VALID/READY 0 immediately, registers = RESET_VALUE. After release, a fresh write/read completes normally.
